// File: rtl/mult_div_unit_pkg.sv
// Shared CPU definitions for the multiply/divide unit: op and FSM encodings,
// iteration count and small sign helpers.
package mult_div_unit_pkg;

    localparam int XLEN       = 32;
    localparam int ITERATIONS = 32;
    localparam int ITER_W     = 6;

    typedef logic [XLEN-1:0] word_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MULT = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic word_t negate_if(input logic neg, input word_t v);
        return neg ? word_t'(-v) : v;
    endfunction

    // 0x80000000 maps to itself, which reads correctly as unsigned 2^31.
    function automatic word_t magnitude(input word_t v);
        return negate_if(v[XLEN-1], v);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Launch/result bus between the control unit (master) and the
// multiply/divide unit (slave).
interface mult_div_unit_if;
    import mult_div_unit_pkg::*;

    logic  start;
    logic  op;
    word_t a;
    word_t b;
    logic  busy;
    logic  done;
    logic  div_zero;
    word_t hi;
    word_t lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_zero, hi, lo
    );

endinterface

// File: rtl/mult_div_unit_div_step.sv
// One restoring-division step on magnitudes: shift the next dividend bit into
// the partial remainder and subtract the divisor when it fits.
module div_step
    import mult_div_unit_pkg::*;
(
    input  word_t rem,
    input  logic  next_bit,
    input  word_t divisor,
    output word_t rem_next,
    output logic  q_bit
);

    logic [XLEN:0] trial;
    logic [XLEN:0] diff;

    // rem < divisor holds on entry, so trial < 2*divisor and bit XLEN of
    // diff is a clean borrow flag.
    always_comb begin
        trial    = {rem, next_bit};
        diff     = trial - {1'b0, divisor};
        q_bit    = ~diff[XLEN];
        rem_next = q_bit ? diff[XLEN-1:0] : trial[XLEN-1:0];
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (Booth radix-2) / divide (restoring) unit with
// HI/LO result registers; 32 cycles per operation.
module mult_div_unit
    import mult_div_unit_pkg::*;
(
    input logic clk,
    input logic reset,
    mult_div_unit_if.slave bus
);

    logic [1:0]        state;
    logic [ITER_W-1:0] iter;
    word_t             operand_m;
    logic [XLEN:0]     acc;
    word_t             shreg;
    logic              booth_bit;
    logic              neg_quot;
    logic              neg_rem;
    word_t             hi_q;
    word_t             lo_q;
    logic              div_zero_q;

    logic [XLEN:0]     booth_addend;
    logic [XLEN:0]     booth_sum;
    logic [XLEN:0]     acc_next;
    word_t             shreg_next;
    logic              booth_bit_next;
    word_t             rem_next;
    logic              q_bit;
    logic              last_iter;

    // DIV reuses the working registers: acc holds the partial remainder,
    // shreg shifts dividend bits out and quotient bits in.
    div_step u_div_step (
        .rem      (acc[XLEN-1:0]),
        .next_bit (shreg[XLEN-1]),
        .divisor  (operand_m),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    assign last_iter    = (iter == ITER_W'(ITERATIONS - 1));
    assign booth_addend = {operand_m[XLEN-1], operand_m};

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        booth_sum      = acc;
        acc_next       = acc;
        shreg_next     = shreg;
        booth_bit_next = booth_bit;
        case ({shreg[0], booth_bit})
            2'b01:   booth_sum = acc + booth_addend;
            2'b10:   booth_sum = acc - booth_addend;
            default: booth_sum = acc;
        endcase
        if (state == ST_MULT) begin
            // The extra accumulator bit keeps -(-2^31) from overflowing.
            acc_next       = {booth_sum[XLEN], booth_sum[XLEN:1]};
            shreg_next     = {booth_sum[0], shreg[XLEN-1:1]};
            booth_bit_next = shreg[0];
        end else if (state == ST_DIV) begin
            acc_next   = {1'b0, rem_next};
            shreg_next = {shreg[XLEN-2:0], q_bit};
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values; reset is synchronous and overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            iter       <= '0;
            operand_m  <= '0;
            acc        <= '0;
            shreg      <= '0;
            booth_bit  <= 1'b0;
            neg_quot   <= 1'b0;
            neg_rem    <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            div_zero_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        iter      <= '0;
                        acc       <= '0;
                        booth_bit <= 1'b0;
                        if (bus.op == OP_MULT) begin
                            operand_m <= bus.a;
                            shreg     <= bus.b;
                            state     <= ST_MULT;
                        end else if (bus.b != '0) begin
                            operand_m <= magnitude(bus.b);
                            shreg     <= magnitude(bus.a);
                            neg_quot  <= bus.a[XLEN-1] ^ bus.b[XLEN-1];
                            neg_rem   <= bus.a[XLEN-1];
                            state     <= ST_DIV;
                        end else begin
                            div_zero_q <= 1'b1;
                        end
                    end
                end
                ST_MULT, ST_DIV: begin
                    acc       <= acc_next;
                    shreg     <= shreg_next;
                    booth_bit <= booth_bit_next;
                    iter      <= iter + 1'b1;
                    if (last_iter) begin
                        state <= ST_DONE;
                        if (state == ST_MULT) begin
                            hi_q <= acc_next[XLEN-1:0];
                            lo_q <= shreg_next;
                        end else begin
                            hi_q <= negate_if(neg_rem, acc_next[XLEN-1:0]);
                            lo_q <= negate_if(neg_quot, shreg_next);
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy     = (state == ST_MULT) || (state == ST_DIV);
    assign bus.done     = (state == ST_DONE);
    assign bus.div_zero = div_zero_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: the driver queues expected events,
// a negedge monitor checks done/div_zero timing and HI/LO contents.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic clk = 1'b0;
    logic reset;

    mult_div_unit_if bus ();

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic  is_dz;
        word_t hi;
        word_t lo;
        int    edge_n;
    } exp_t;

    exp_t  sb[$];
    exp_t  mon_e;
    int    checks   = 0;
    int    errors   = 0;
    int    edge_cnt = 0;
    logic  rst_q    = 1'b1;
    bit    mon_en   = 1'b0;
    word_t model_hi = '0;
    word_t model_lo = '0;

    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        rst_q    <= reset;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Monitor: edge_cnt at a negedge is the number of the last rising edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_q) begin
                model_hi = '0;
                model_lo = '0;
            end
            if (bus.done || bus.div_zero) begin
                check("done_dz_exclusive", 64'(bus.done & bus.div_zero), 64'd0);
                if (sb.size() == 0) begin
                    check("unexpected_event", 64'({bus.done, bus.div_zero}), 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("event_kind", 64'(bus.div_zero), 64'(mon_e.is_dz));
                    check("event_edge", 64'(edge_cnt), 64'(mon_e.edge_n));
                    if (!mon_e.is_dz) begin
                        model_hi = mon_e.hi;
                        model_lo = mon_e.lo;
                    end
                end
            end
            check("hi", 64'(bus.hi), 64'(model_hi));
            check("lo", 64'(bus.lo), 64'(model_lo));
        end
    end

    // Drive start now (caller is at a negedge) and queue the expected event.
    task automatic issue_now(input logic op, input word_t a, input word_t b,
                             input logic is_dz, input word_t hi, input word_t lo);
        exp_t e;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        e.is_dz   = is_dz;
        e.hi      = hi;
        e.lo      = lo;
        e.edge_n  = edge_cnt + 1 + (is_dz ? 0 : ITERATIONS);
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic issue(input logic op, input word_t a, input word_t b,
                         input logic is_dz, input word_t hi, input word_t lo);
        @(negedge clk);
        issue_now(op, a, b, is_dz, hi, lo);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int busy_cnt;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = OP_MULT;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_dz", 64'(bus.div_zero), 64'd0);
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        mon_en = 1'b1;
        reset  = 1'b0;

        // MULT 7 * -3 with busy window: high for exactly 32 sampled cycles.
        issue(OP_MULT, 32'd7, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        busy_cnt = 0;
        check("busy_first", 64'(bus.busy), 64'd1);
        for (int i = 0; i < 34; i++) begin
            if (bus.busy) busy_cnt++;
            @(negedge clk);
        end
        check("busy_cycles", 64'(busy_cnt), 64'd32);
        wait_drain();

        issue(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0000_0000);
        wait_drain();
        issue(OP_MULT, 32'h1234_5678, 32'h0000_0010, 1'b0, 32'h0000_0001, 32'h2345_6780);
        wait_drain();
        issue(OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0, 32'h0000_0001, 32'hFFFF_FFFD);
        wait_drain();
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        wait_drain();
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h8000_0000);
        wait_drain();

        // Set HI/LO to 0x11/0x22, then divide by zero.
        issue(OP_DIV, 32'h0000_0451, 32'h0000_0020, 1'b0, 32'h0000_0011, 32'h0000_0022);
        wait_drain();
        issue(OP_DIV, 32'd5, 32'd0, 1'b1, 32'h0, 32'h0);
        #1;
        check("dz_busy0", 64'(bus.busy), 64'd0);
        @(negedge clk);
        #1;
        check("dz_busy1", 64'(bus.busy), 64'd0);
        check("dz_single_pulse", 64'(bus.div_zero), 64'd0);
        check("dz_hold_hi", 64'(bus.hi), 64'h11);
        check("dz_hold_lo", 64'(bus.lo), 64'h22);
        wait_drain();

        // Start ignored in the middle of a MULT.
        issue(OP_MULT, 32'd1000, 32'hFFFF_FC18, 1'b0, 32'hFFFF_FFFF, 32'hFFF0_BDC0);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.a     = 32'd9;
        bus.b     = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        wait_drain();
        repeat (40) @(negedge clk);

        // Start presented in the DONE cycle is ignored.
        issue(OP_MULT, 32'd3, 32'd5, 1'b0, 32'h0, 32'hF);
        repeat (32) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MULT;
        bus.a     = 32'd2;
        bus.b     = 32'd2;
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        check("done_start_busy", 64'(bus.busy), 64'd0);
        wait_drain();
        repeat (40) @(negedge clk);

        // Reset aborts a MULT at N+10: no done, HI/LO cleared.
        issue(OP_MULT, 32'h0000_1234, 32'h0000_0010, 1'b0, 32'h0, 32'h0001_2340);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_hi", 64'(bus.hi), 64'd0);
        check("abort_lo", 64'(bus.lo), 64'd0);
        repeat (40) @(negedge clk);

        // Start accepted on the first edge after reset deasserts.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        issue_now(OP_DIV, 32'd100, 32'd7, 1'b0, 32'h0000_0002, 32'h0000_000E);
        wait_drain();
        issue(OP_DIV, 32'hFFFF_FF9C, 32'd7, 1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFF2);
        wait_drain();
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, reset (synchronous, active-high).
REQ-003 SHALL have port start, input, 1, launch request from control unit (Es_Mult_Div state).
REQ-004 SHALL have port op, input, 1, operation select: 0 = MULT, 1 = DIV.
REQ-005 SHALL have port a, input, 32, operand A (rs), two's complement.
REQ-006 SHALL have port b, input, 32, operand B (rt), two's complement.
REQ-007 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-008 SHALL have port done, output, 1, one-cycle pulse when hi/lo hold a new result.
REQ-009 SHALL have port div_zero, output, 1, one-cycle pulse on DIV with b = 0.
REQ-010 SHALL have port hi, output, 32, HI result register.
REQ-011 SHALL have port lo, output, 32, LO result register.

Function
REQ-012 SHALL implement FSM states IDLE, MULT, DIV, DONE.
REQ-013 SHALL sample start, op, a and b only in IDLE; start in any other state is ignored.
REQ-014 SHALL go IDLE->MULT on start with op = 0, and IDLE->DIV on start with op = 1 and b != 0; operands are latched on that edge.
REQ-015 SHALL, on start with op = 1 and b = 0, stay in IDLE, pulse div_zero on the next cycle, leave hi/lo unchanged, and not assert done or busy.
REQ-016 SHALL perform exactly 32 iterations (one per cycle) in MULT or DIV, counted by a 6-bit iteration counter, then enter DONE.
REQ-017 SHALL, for MULT, compute the signed 64-bit product a*b (Booth radix-2 or equivalent): hi = bits 63:32, lo = bits 31:0.
REQ-018 SHALL, for DIV, compute signed division truncated toward zero: lo = quotient, hi = remainder with the sign of the dividend (|hi| < |b|).
REQ-019 SHALL produce lo = 0x80000000 and hi = 0 for DIV of 0x80000000 by 0xFFFFFFFF, without flagging an error.
REQ-020 SHALL, with start accepted at edge N, update hi/lo and assert done for exactly cycle N+33; busy is high from N+1 through N+32 inclusive.
REQ-021 SHALL go DONE->IDLE unconditionally after one cycle; a start in the DONE cycle is ignored.
REQ-022 SHALL hold hi/lo stable between completions; intermediate working registers are never visible on hi/lo.
REQ-023 SHALL keep done and div_zero mutually exclusive and never asserted for more than one cycle.

Reset
REQ-024 SHALL, with reset high at a rising edge, force state IDLE and busy = 0, done = 0, div_zero = 0, hi = 0, lo = 0, and iteration counter = 0.
REQ-025 SHALL give reset priority over start and over any in-progress operation; an aborted operation produces no done and no hi/lo update.
REQ-026 SHALL accept a new start on the first edge after reset deasserts.

Structure
REQ-027 SHALL take the op encodings (OP_MULT, OP_DIV), FSM state encodings and ITERATIONS = 32 from the shared CPU package used by the control unit.
REQ-028 SHALL isolate one restoring-division step in a combinational sub-module div_step (partial remainder, divisor -> next remainder, quotient bit); multiplication stays in the top level.

Verification
REQ-029 SHALL verify MULT a = 7, b = 0xFFFFFFFD (-3), start at edge N -> done at N+33 only, hi = 0xFFFFFFFF, lo = 0xFFFFFFEB.
REQ-030 SHALL verify MULT a = b = 0x80000000 -> hi = 0x40000000, lo = 0x00000000.
REQ-031 SHALL verify DIV 7 / -2 -> lo = 0xFFFFFFFD, hi = 0x00000001; and DIV -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
REQ-032 SHALL verify that with prior hi = 0x11, lo = 0x22, DIV a = 5, b = 0 -> div_zero pulses at N+1, busy stays 0, no done, hi/lo remain 0x11/0x22.
REQ-033 SHALL verify that after MULT start at N, reset at N+10 -> next cycle busy = 0, hi = lo = 0, and no done within 40 cycles.
REQ-034 SHALL verify that during MULT, a start with op = 1, a = 9, b = 3 at N+5 is ignored -> result equals the original MULT and done occurs only once.
